// File: rtl/dpram_port_pkg.sv
// rtl/dpram_port_pkg.sv - default widths and tracking types for dpram_port_master
// Optional macro DPRAM_RAW_FWD_EN adds the fwd/data fields to rd_tag_t.
package dpram_port_pkg;

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDRESS_WIDTH = 3;
  localparam int DEF_RSP_DEPTH     = 4;
  localparam int CNT_W             = $clog2(DEF_RSP_DEPTH + 1);

  typedef struct packed {
    logic                         valid;
    logic [DEF_ADDRESS_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0]    data;
  } wr_track_t;

`ifdef DPRAM_RAW_FWD_EN
  typedef struct packed {
    logic                      valid;
    logic                      fwd;
    logic [DEF_DATA_WIDTH-1:0] data;
  } rd_tag_t;
`else
  typedef struct packed {
    logic valid;
  } rd_tag_t;
`endif

endpackage

// File: rtl/dpram_rsp_fifo.sv
// rtl/dpram_rsp_fifo.sv - first-word fall-through response FIFO
// Push and pop may coincide even when full; dout reads as zero while empty.
module dpram_rsp_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int RSP_DEPTH  = 4,
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(RSP_DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dpram_port_master.sv
// rtl/dpram_port_master.sv - request initiator for one port of the dual-port latency RAM
// Optional macro DPRAM_RAW_FWD_EN forwards pending write data instead of stalling hazard reads.
module dpram_port_master
  import dpram_port_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int READ_LATENCY  = 1,
  parameter int WRITE_LATENCY = 1,
  parameter int RSP_DEPTH     = DEF_RSP_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_din,
  input  logic [DATA_WIDTH-1:0]    mem_dout,
  output logic                     idle
);

  localparam int INF_W = $clog2(RSP_DEPTH + 1);

  wr_track_t             wr_pipe [WRITE_LATENCY];
  rd_tag_t               rd_pipe [READ_LATENCY];
  rd_tag_t               rd_out;
  logic [INF_W-1:0]      inflight;
  logic [INF_W-1:0]      fifo_count;
  logic                  ready_en;
  logic                  fire;
  logic                  wr_fire;
  logic                  rd_fire;
  logic                  rd_ok;
  logic                  credit_ok;
  logic                  hazard;
  logic                  pop;
  logic                  fifo_push;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic [DATA_WIDTH-1:0] fifo_din;
  logic                  unused_fifo;
`ifdef DPRAM_RAW_FWD_EN
  logic [DATA_WIDTH-1:0] fwd_data;
`endif

  always_comb begin
    hazard = 1'b0;
`ifdef DPRAM_RAW_FWD_EN
    fwd_data = '0;
`endif
    // Scan oldest to youngest so the youngest matching write supplies the data.
    for (int i = WRITE_LATENCY - 1; i >= 0; i--) begin
      if (wr_pipe[i].valid && (wr_pipe[i].addr == req_addr)) begin
        hazard = 1'b1;
`ifdef DPRAM_RAW_FWD_EN
        fwd_data = wr_pipe[i].data;
`endif
      end
    end
  end

  assign credit_ok = (inflight < INF_W'(RSP_DEPTH));
`ifdef DPRAM_RAW_FWD_EN
  assign rd_ok = credit_ok;
`else
  assign rd_ok = credit_ok && !hazard;
`endif

  assign req_ready = ready_en && (req_we || rd_ok);
  assign fire      = req_valid && req_ready;
  assign wr_fire   = fire && req_we;
  assign rd_fire   = fire && !req_we;
  assign mem_en    = fire;
  assign mem_we    = req_we;
  assign mem_addr  = req_addr;
  assign mem_din   = req_wdata;

  assign pop       = rsp_valid && rsp_ready;
  assign rd_out    = rd_pipe[READ_LATENCY-1];
  assign fifo_push = rd_out.valid;
`ifdef DPRAM_RAW_FWD_EN
  assign fifo_din  = rd_out.fwd ? rd_out.data : mem_dout;
`else
  assign fifo_din  = mem_dout;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      inflight <= '0;
      for (int i = 0; i < WRITE_LATENCY; i++) wr_pipe[i] <= '0;
      for (int i = 0; i < READ_LATENCY; i++)  rd_pipe[i] <= '0;
    end else begin
      ready_en         <= 1'b1;
      wr_pipe[0].valid <= wr_fire;
      wr_pipe[0].addr  <= req_addr;
      wr_pipe[0].data  <= req_wdata;
      for (int i = 1; i < WRITE_LATENCY; i++) wr_pipe[i] <= wr_pipe[i-1];
      rd_pipe[0].valid <= rd_fire;
`ifdef DPRAM_RAW_FWD_EN
      rd_pipe[0].fwd   <= hazard;
      rd_pipe[0].data  <= fwd_data;
`endif
      for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
      case ({rd_fire, pop})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  dpram_rsp_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .RSP_DEPTH  (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (rsp_rdata),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign rsp_valid   = !fifo_empty;
  assign unused_fifo = ^{fifo_full, fifo_count};

  always_comb begin
    idle = fifo_empty;
    for (int i = 0; i < WRITE_LATENCY; i++) if (wr_pipe[i].valid) idle = 1'b0;
    for (int i = 0; i < READ_LATENCY; i++)  if (rd_pipe[i].valid) idle = 1'b0;
  end

endmodule
